// File: rtl/bits_tx_serializer.sv
// bits_tx_serializer: buffers 8-bit duty-cycle samples in a 2-entry FIFO and
// shifts them MSB-first onto a continuous one-bit-per-clk16 line. There are no
// framing bits. When the FIFO is starved, the last word is re-sent.
`timescale 1ns/1ps

module bits_tx_serializer #(
   // Only a depth of 2 is supported; the FIFO pointers are one bit wide.
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic       clk16,
   input  logic       rst,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   output logic       sample_ready,
   output logic       data,
   output logic       word_start,
   output logic       underrun
);

   localparam logic [1:0] FullCount = 2'(FIFO_DEPTH);

   // Sample FIFO state.
   logic [7:0] fifo_mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;

   // Serializer state.
   logic [7:0] shreg;
   logic [7:0] last;
   logic [2:0] bitcnt;

   logic       load;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   logic [7:0] next_word;

   // Handshake and load decode. Readiness comes only from registered occupancy.
   always_comb begin
      fifo_empty   = (count == 2'd0);
      sample_ready = (count != FullCount);
      load         = (bitcnt == 3'd7);
      push         = sample_valid & sample_ready;
      // A push into an empty FIFO is not visible to this same-cycle load.
      pop          = load & ~fifo_empty;
      next_word    = fifo_empty ? last : fifo_mem[rd_ptr];
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk16 or negedge rst) begin
      if (!rst) begin
         fifo_mem[0] <= 8'h00;
         fifo_mem[1] <= 8'h00;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= sample_in;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Shift-out and word-load sequencing on a fixed 8-cycle grid.
   always_ff @(posedge clk16 or negedge rst) begin
      if (!rst) begin
         shreg      <= 8'h00;
         last       <= 8'h00;
         bitcnt     <= 3'd0;
         data       <= 1'b0;
         word_start <= 1'b0;
         underrun   <= 1'b0;
      end else if (load) begin
         shreg      <= next_word;
         last       <= next_word;
         data       <= next_word[7];
         bitcnt     <= 3'd0;
         word_start <= 1'b1;
         underrun   <= fifo_empty;
      end else begin
         // The MSB was already driven on the load edge, so bitcnt is one step behind the bit index.
         data       <= shreg[3'd6 - bitcnt];
         bitcnt     <= bitcnt + 3'd1;
         word_start <= 1'b0;
         underrun   <= 1'b0;
      end
   end

endmodule

// File: doc/bits_tx_serializer.md
# bits_tx_serializer

Transmit-side counterpart of the PWM modulator's serial bit receiver. Accepts 8-bit duty-cycle samples over a valid/ready handshake, buffers them in a 2-entry FIFO, and shifts them out MSB-first on a single continuous bit line. The line carries exactly one bit per `clk16` cycle with no framing bits, so the receiver's 8-bit word boundary stays aligned from reset. On starvation the last word is re-sent, so the far-end PWM holds its duty cycle.

## Interface
- `FIFO_DEPTH`, default 2: sample buffer depth. Only 2 is supported.
- `clk16`  in  1  bit clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sample_in`  in  8  duty-cycle sample; bit 7 is sent first.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_ready`  out  1  FIFO is not full. Driven from registered occupancy only, never from a same-cycle pop.
- `data`  out  1  registered serial bit line to the receiver.
- `word_start`  out  1  registered; high for exactly the cycle in which a word's MSB is on `data`.
- `underrun`  out  1  registered one-cycle pulse: a word load found the FIFO empty and re-sent the last word.

## Operation
- Push: the FIFO stores `sample_in` when `sample_valid && sample_ready`. If `sample_valid` is high while `sample_ready` is low, the sample is ignored and not queued.
- Internal registers:
  - `shreg[7:0]`: word currently being sent; reset 0x00.
  - `last[7:0]`: last word loaded; reset 0x00.
  - `bitcnt[2:0]`: reset 0.
- Every edge with `bitcnt != 7`:
  - `data <= shreg[6 - bitcnt]`
  - `bitcnt <= bitcnt + 1`
- Every edge with `bitcnt == 7` (load edge):
  - `next` = FIFO head if the FIFO is non-empty (pop), else `last`.
  - `shreg <= next`, `last <= next`, `data <= next[7]`, `bitcnt <= 0`, `word_start <= 1`.
  - `underrun <= 1` if the FIFO was empty.
- On all other edges, `word_start <= 0` and `underrun <= 0`.
- Push and pop in the same cycle:
  - Non-empty FIFO: the pop takes the old head and the push appends; occupancy is unchanged.
  - Empty FIFO: the pushed word is NOT visible to this load. The load is an underrun (re-sends `last`), and the pushed word is sent by the next load.
- Full FIFO: `sample_ready` is 0, so no push can occur; a pop that cycle raises `sample_ready` on the next cycle.
- Reset word: the line carries word 0x00 from reset release until the first load edge, with `data = 0` throughout.

## Timing
- Reset values: `data = 0`, `word_start = 0`, `underrun = 0`, `sample_ready = 1` (FIFO empty), `bitcnt = 0`.
- Number the edges after reset deassertion 1, 2, 3, and so on.
  - Word k (k ≥ 1) is loaded at edge 8k; its bit (7 − i) is driven after edge 8k + i.
  - The receiver, which samples on the same edges, captures word k at edge 8k + 8.
- Word period: exactly 8 cycles, with no gaps.
- Load edges are at edges 8, 16, 24, …; `word_start` is high during cycles 8k..8k+1.
- Push-to-line latency:
  - Minimum: a sample pushed at edge e < 8k into an empty FIFO has its MSB on `data` after edge 8k.
  - Maximum: 8·(occupancy + 1) cycles.
- Reset asserted mid-word:
  - All registers clear immediately and the FIFO empties.
  - The partially sent word is abandoned.
  - The 8-cycle word grid restarts from the reset-release edge, matching the receiver's reset.

## Test plan
- Reset, then no pushes → `data` stays 0 indefinitely; `underrun` pulses at edges 8, 16, 24; `word_start` pulses at the same edges; `sample_ready` = 1.
- Push 0xA5 at edge 3 → `data` = 1,0,1,0,0,1,0,1 after edges 8..15; `word_start` high only in cycle 8; no `underrun` at edge 8; `underrun` at edge 16 with 0xA5 re-sent.
- Push 0x80, 0x01, 0xFF at edges 1, 2, 3 → `sample_ready` drops after edge 2; the edge-3 push is ignored; the line carries 0x80 then 0x01, then 0x01 repeats with `underrun`.
- Push 0x3C exactly at edge 8 into an empty FIFO → the edge-8 load re-sends 0x00 and flags `underrun`; 0x3C is sent from edge 16.
- Keep the FIFO full (feed on every `sample_ready`) with incrementing values 0x00..0xFF → a reference receiver model (8-bit MSB-first shift, capture every 8th edge) reproduces the exact sequence with zero `underrun` pulses.
- Assert `rst` low at edge 20 (mid-word) for 3 cycles → all outputs return to reset values asynchronously; after release, the next load is at the 8th edge and a pushed 0x55 appears intact.
